// File: rtl/rv32i_pkg.sv
// rv32i_pkg -- shared RV32I definitions for the writeback slice.
// Holds the default datapath/register-address widths, the writeback
// source encoding and the load funct3 codes used by wb_stage and load_align.
package rv32i_pkg;

    localparam int D_WIDTH_DEF = 32;
    localparam int A_WIDTH_DEF = 5;

    // Writeback source select carried down the pipe from decode
    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'b00,
        WB_SEL_LOAD = 2'b01,
        WB_SEL_PC4  = 2'b10,
        WB_SEL_RSVD = 2'b11
    } wb_sel_e;

    // Load funct3 codes; 011, 110 and 111 are not legal loads on RV32I
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// load_align -- purely combinational load data alignment.
// Picks the addressed byte/halfword out of the synchronous data-memory word
// and sign- or zero-extends it. Unsupported funct3 codes return zero and
// raise illegal so the writeback stage can suppress the register write.
module load_align
    import rv32i_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF
) (
    input  logic [D_WIDTH-1:0] rdata,
    input  logic [2:0]         funct3,
    input  logic [1:0]         addr_lo,
    output logic [D_WIDTH-1:0] data,
    output logic               illegal
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the lane, then extend according to the load type
    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
        data     = '0;
        illegal  = 1'b0;
        case (funct3)
            F3_LB:   data = {{(D_WIDTH-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {{(D_WIDTH-8){1'b0}}, byte_sel};
            F3_LH:   data = {{(D_WIDTH-16){half_sel[15]}}, half_sel};
            F3_LHU:  data = {{(D_WIDTH-16){1'b0}}, half_sel};
            F3_LW:   data = rdata;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage -- MEM/WB pipeline register plus writeback mux.
// Outputs are combinational from the MEM/WB register (and the synchronous
// dmem word) so they settle in the high phase for a falling-edge register file.
// Optional feature: define WB_INSTRET_EN to build the 64-bit retired
// instruction counter on o_instret; otherwise o_instret is tied to zero.
module wb_stage
    import rv32i_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int A_WIDTH = A_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic               i_valid,
    input  logic [A_WIDTH-1:0] i_rd,
    input  logic               i_wen,
    input  logic [1:0]         i_wb_sel,
    input  logic [D_WIDTH-1:0] i_alu_result,
    input  logic [D_WIDTH-1:0] i_pc_plus4,
    input  logic [2:0]         i_funct3,
    input  logic [1:0]         i_addr_lo,
    input  logic [D_WIDTH-1:0] i_dmem_rdata,
    output logic               o_wen_rf,
    output logic [A_WIDTH-1:0] o_waddr,
    output logic [D_WIDTH-1:0] o_wdata,
    output logic               o_illegal_load,
    output logic [63:0]        o_instret
);

    logic               valid_q;
    logic               wen_q;
    logic [A_WIDTH-1:0] rd_q;
    wb_sel_e            sel_q;
    logic [D_WIDTH-1:0] alu_q;
    logic [D_WIDTH-1:0] pc4_q;
    logic [2:0]         funct3_q;
    logic [1:0]         addr_lo_q;

    logic [D_WIDTH-1:0] load_data;
    logic               load_illegal;
    logic               wen_ok;

    // MEM/WB register: flush inserts a bubble even when stalled, stall holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            wen_q     <= 1'b0;
            rd_q      <= '0;
            sel_q     <= WB_SEL_ALU;
            alu_q     <= '0;
            pc4_q     <= '0;
            funct3_q  <= '0;
            addr_lo_q <= '0;
        end else if (i_flush) begin
            valid_q   <= 1'b0;
        end else if (!i_stall) begin
            valid_q   <= i_valid;
            wen_q     <= i_wen;
            rd_q      <= i_rd;
            sel_q     <= wb_sel_e'(i_wb_sel);
            alu_q     <= i_alu_result;
            pc4_q     <= i_pc_plus4;
            funct3_q  <= i_funct3;
            addr_lo_q <= i_addr_lo;
        end
    end

    load_align #(
        .D_WIDTH (D_WIDTH)
    ) u_load_align (
        .rdata   (i_dmem_rdata),
        .funct3  (funct3_q),
        .addr_lo (addr_lo_q),
        .data    (load_data),
        .illegal (load_illegal)
    );

    // Writeback mux; reserved select and illegal loads write nothing
    always_comb begin
        wen_ok         = valid_q & wen_q & (rd_q != '0);
        o_wdata        = '0;
        o_illegal_load = 1'b0;
        case (sel_q)
            WB_SEL_ALU:  o_wdata = alu_q;
            WB_SEL_LOAD: begin
                o_wdata        = load_data;
                o_illegal_load = valid_q & load_illegal;
                if (load_illegal) begin
                    wen_ok = 1'b0;
                end
            end
            WB_SEL_PC4:  o_wdata = pc4_q;
            default:     wen_ok  = 1'b0;
        endcase
    end

    assign o_wen_rf = wen_ok;
    assign o_waddr  = rd_q;

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q;

    // Count an instruction as retired when it leaves WB without a stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (valid_q && !i_stall) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign o_instret = instret_q;
`else
    assign o_instret = 64'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage -- directed testbench for wb_stage.
// A behavioural model of the writeback register is checked against the DUT
// on every falling edge; directed vectors add hand-computed expectations.
// Honours WB_INSTRET_EN the same way as the design.
module tb_wb_stage;
    import rv32i_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk            = 1'b0;
    logic          rst_n          = 1'b0;
    logic          i_stall        = 1'b0;
    logic          i_flush        = 1'b0;
    logic          i_valid        = 1'b0;
    logic [AW-1:0] i_rd           = '0;
    logic          i_wen          = 1'b0;
    logic [1:0]    i_wb_sel       = 2'b00;
    logic [DW-1:0] i_alu_result   = '0;
    logic [DW-1:0] i_pc_plus4     = '0;
    logic [2:0]    i_funct3       = 3'b000;
    logic [1:0]    i_addr_lo      = 2'b00;
    logic [DW-1:0] i_dmem_rdata   = '0;
    logic          o_wen_rf;
    logic [AW-1:0] o_waddr;
    logic [DW-1:0] o_wdata;
    logic          o_illegal_load;
    logic [63:0]   o_instret;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    typedef struct packed {
        logic          valid;
        logic          wen;
        logic [AW-1:0] rd;
        logic [1:0]    sel;
        logic [DW-1:0] alu;
        logic [DW-1:0] pc4;
        logic [2:0]    f3;
        logic [1:0]    alo;
    } wb_entry_t;

    wb_entry_t   m_wb      = '0;
    logic [63:0] m_instret = '0;
    logic [63:0] instret_snap;

    wb_stage #(
        .D_WIDTH (DW),
        .A_WIDTH (AW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_stall        (i_stall),
        .i_flush        (i_flush),
        .i_valid        (i_valid),
        .i_rd           (i_rd),
        .i_wen          (i_wen),
        .i_wb_sel       (i_wb_sel),
        .i_alu_result   (i_alu_result),
        .i_pc_plus4     (i_pc_plus4),
        .i_funct3       (i_funct3),
        .i_addr_lo      (i_addr_lo),
        .i_dmem_rdata   (i_dmem_rdata),
        .o_wen_rf       (o_wen_rf),
        .o_waddr        (o_waddr),
        .o_wdata        (o_wdata),
        .o_illegal_load (o_illegal_load),
        .o_instret      (o_instret)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkWb(input string tag, input logic we, input logic [AW-1:0] wa,
                           input logic [DW-1:0] wd, input logic ill);
        checkOutput({tag, "_wen"},     {63'd0, o_wen_rf},       {63'd0, we});
        checkOutput({tag, "_waddr"},   {59'd0, o_waddr},        {59'd0, wa});
        checkOutput({tag, "_wdata"},   {32'd0, o_wdata},        {32'd0, wd});
        checkOutput({tag, "_illegal"}, {63'd0, o_illegal_load}, {63'd0, ill});
    endtask

    // Expected writeback outputs computed from the load/select rules with plain arithmetic
    function automatic void model_outputs(input wb_entry_t e, input logic [DW-1:0] rdata,
                                          output logic we, output logic [DW-1:0] wd,
                                          output logic ill);
        int unsigned b;
        int unsigned h;
        int unsigned off;
        off = {30'd0, e.alo};
        b   = (rdata >> (8 * off)) & 32'hFF;
        h   = (rdata >> (16 * (off / 2))) & 32'hFFFF;
        we  = e.valid && e.wen && (e.rd != 0);
        wd  = '0;
        ill = 1'b0;
        case (e.sel)
            2'b00: wd = e.alu;
            2'b10: wd = e.pc4;
            2'b11: we = 1'b0;
            default: begin
                case (e.f3)
                    3'b000: wd = (b >= 128)   ? b - 256   : b;
                    3'b100: wd = b;
                    3'b001: wd = (h >= 32768) ? h - 65536 : h;
                    3'b101: wd = h;
                    3'b010: wd = rdata;
                    default: begin
                        we  = 1'b0;
                        ill = e.valid;
                    end
                endcase
            end
        endcase
    endfunction

    // Model of the MEM/WB register and retired-instruction count
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wb      <= '0;
            m_instret <= '0;
        end else begin
`ifdef WB_INSTRET_EN
            if (m_wb.valid && !i_stall) m_instret <= m_instret + 64'd1;
`endif
            if (i_flush) begin
                m_wb.valid <= 1'b0;
            end else if (!i_stall) begin
                m_wb <= '{i_valid, i_wen, i_rd, i_wb_sel, i_alu_result, i_pc_plus4, i_funct3, i_addr_lo};
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        logic          exp_we;
        logic [DW-1:0] exp_wd;
        logic          exp_ill;
        if (cmp_en) begin
            model_outputs(m_wb, i_dmem_rdata, exp_we, exp_wd, exp_ill);
            checkWb("cyc", exp_we, m_wb.rd, exp_wd, exp_ill);
            checkOutput("cyc_instret", o_instret, m_instret);
        end
    end

    task automatic applyStimulus(input logic v, input logic [AW-1:0] rd, input logic wen,
                                 input logic [1:0] sel, input logic [DW-1:0] alu,
                                 input logic [DW-1:0] pc4, input logic [2:0] f3,
                                 input logic [1:0] alo, input logic stall, input logic flush,
                                 input logic [DW-1:0] rdata);
        i_valid      = v;
        i_rd         = rd;
        i_wen        = wen;
        i_wb_sel     = sel;
        i_alu_result = alu;
        i_pc_plus4   = pc4;
        i_funct3     = f3;
        i_addr_lo    = alo;
        i_stall      = stall;
        i_flush      = flush;
        @(posedge clk);
        #1;
        i_dmem_rdata = rdata;
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        @(posedge clk);
        #1;
        cmp_en = 1'b1;
        @(posedge clk);
        #2;
        checkWb("reset", 1'b0, 5'd0, 32'd0, 1'b0);
        checkOutput("reset_instret", o_instret, 64'd0);
        rst_n = 1'b1;

        // ALU writes: rd=0 suppressed, rd=5 written
        applyStimulus(1'b1, 5'd0, 1'b1, 2'b00, 32'h1234, 32'h0, F3_LB, 2'd0, 1'b0, 1'b0, 32'h0);
        checkWb("alu_rd0", 1'b0, 5'd0, 32'h1234, 1'b0);
        applyStimulus(1'b1, 5'd5, 1'b1, 2'b00, 32'h1234, 32'h0, F3_LB, 2'd0, 1'b0, 1'b0, 32'h0);
        checkWb("alu_rd5", 1'b1, 5'd5, 32'h1234, 1'b0);

        // Load alignment vectors
        applyStimulus(1'b1, 5'd7, 1'b1, 2'b01, 32'h0, 32'h0, F3_LB, 2'd3, 1'b0, 1'b0, 32'h80FF_0000);
        checkWb("lb", 1'b1, 5'd7, 32'hFFFF_FF80, 1'b0);
        applyStimulus(1'b1, 5'd7, 1'b1, 2'b01, 32'h0, 32'h0, F3_LBU, 2'd3, 1'b0, 1'b0, 32'h80FF_0000);
        checkWb("lbu", 1'b1, 5'd7, 32'h0000_0080, 1'b0);
        applyStimulus(1'b1, 5'd8, 1'b1, 2'b01, 32'h0, 32'h0, F3_LH, 2'd2, 1'b0, 1'b0, 32'h8001_1234);
        checkWb("lh", 1'b1, 5'd8, 32'hFFFF_8001, 1'b0);
        applyStimulus(1'b1, 5'd8, 1'b1, 2'b01, 32'h0, 32'h0, F3_LHU, 2'd2, 1'b0, 1'b0, 32'h8001_1234);
        checkWb("lhu", 1'b1, 5'd8, 32'h0000_8001, 1'b0);
        applyStimulus(1'b1, 5'd10, 1'b1, 2'b01, 32'h0, 32'h0, F3_LW, 2'd0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        checkWb("lw", 1'b1, 5'd10, 32'hDEAD_BEEF, 1'b0);
        applyStimulus(1'b1, 5'd11, 1'b1, 2'b01, 32'h0, 32'h0, F3_LH, 2'd3, 1'b0, 1'b0, 32'h7FFF_0001);
        checkWb("lh_odd", 1'b1, 5'd11, 32'h0000_7FFF, 1'b0);
        applyStimulus(1'b1, 5'd12, 1'b1, 2'b01, 32'h0, 32'h0, F3_LB, 2'd1, 1'b0, 1'b0, 32'h0000_7F00);
        checkWb("lb_pos", 1'b1, 5'd12, 32'h0000_007F, 1'b0);

        // Illegal loads and reserved select
        applyStimulus(1'b1, 5'd9, 1'b1, 2'b01, 32'h0, 32'h0, 3'b011, 2'd0, 1'b0, 1'b0, 32'h1234_5678);
        checkWb("ill_011", 1'b0, 5'd9, 32'h0, 1'b1);
        applyStimulus(1'b1, 5'd9, 1'b1, 2'b01, 32'h0, 32'h0, 3'b110, 2'd0, 1'b0, 1'b0, 32'h1234_5678);
        checkWb("ill_110", 1'b0, 5'd9, 32'h0, 1'b1);
        applyStimulus(1'b0, 5'd9, 1'b1, 2'b01, 32'h0, 32'h0, 3'b111, 2'd0, 1'b0, 1'b0, 32'h1234_5678);
        checkWb("ill_bubble", 1'b0, 5'd9, 32'h0, 1'b0);
        applyStimulus(1'b1, 5'd9, 1'b1, 2'b11, 32'h55, 32'h66, F3_LW, 2'd0, 1'b0, 1'b0, 32'h0);
        checkWb("sel_rsvd", 1'b0, 5'd9, 32'h0, 1'b0);

        // JAL held by a three-cycle stall, then released
        applyStimulus(1'b1, 5'd1, 1'b1, 2'b10, 32'h0, 32'h100, F3_LB, 2'd0, 1'b0, 1'b0, 32'h0);
        checkWb("jal", 1'b1, 5'd1, 32'h100, 1'b0);
        instret_snap = m_instret;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'd2, 1'b1, 2'b00, 32'hBAD, 32'h0, F3_LB, 2'd0, 1'b1, 1'b0, 32'h0);
            checkWb("jal_stall", 1'b1, 5'd1, 32'h100, 1'b0);
`ifdef WB_INSTRET_EN
            checkOutput("jal_stall_instret", o_instret, instret_snap);
`else
            checkOutput("jal_stall_instret", o_instret, 64'd0);
`endif
        end
        applyStimulus(1'b0, 5'd2, 1'b1, 2'b00, 32'hBAD, 32'h0, F3_LB, 2'd0, 1'b0, 1'b0, 32'h0);
        checkOutput("jal_release_wen", {63'd0, o_wen_rf}, 64'd0);
`ifdef WB_INSTRET_EN
        checkOutput("jal_release_instret", o_instret, instret_snap + 64'd1);
`else
        checkOutput("jal_release_instret", o_instret, 64'd0);
`endif

        // Flush with and without stall
        applyStimulus(1'b1, 5'd3, 1'b1, 2'b00, 32'h77, 32'h0, F3_LB, 2'd0, 1'b0, 1'b0, 32'h0);
        checkWb("pre_flush", 1'b1, 5'd3, 32'h77, 1'b0);
        applyStimulus(1'b1, 5'd4, 1'b1, 2'b00, 32'h88, 32'h0, F3_LB, 2'd0, 1'b1, 1'b1, 32'h0);
        checkOutput("flush_stall_wen", {63'd0, o_wen_rf}, 64'd0);
        applyStimulus(1'b1, 5'd4, 1'b1, 2'b00, 32'h88, 32'h0, F3_LB, 2'd0, 1'b0, 1'b1, 32'h0);
        checkOutput("flush_wen", {63'd0, o_wen_rf}, 64'd0);
        applyStimulus(1'b1, 5'd4, 1'b1, 2'b00, 32'h88, 32'h0, F3_LB, 2'd0, 1'b0, 1'b0, 32'h0);
        checkWb("post_flush", 1'b1, 5'd4, 32'h88, 1'b0);

        // Reset pulsed while an instruction is held by a stall
        applyStimulus(1'b1, 5'd6, 1'b1, 2'b00, 32'hABC, 32'h0, F3_LB, 2'd0, 1'b0, 1'b0, 32'h0);
        checkWb("pre_rst", 1'b1, 5'd6, 32'hABC, 1'b0);
        applyStimulus(1'b1, 5'd13, 1'b1, 2'b00, 32'hDEF, 32'h0, F3_LB, 2'd0, 1'b1, 1'b0, 32'h0);
        checkWb("held", 1'b1, 5'd6, 32'hABC, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        checkWb("rst_mid", 1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("rst_mid_instret", o_instret, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkWb("rst_release", 1'b0, 5'd0, 32'h0, 1'b0);
        applyStimulus(1'b0, 5'd0, 1'b0, 2'b00, 32'h0, 32'h0, F3_LB, 2'd0, 1'b0, 1'b0, 32'h0);
        checkWb("rst_discard", 1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("rst_discard_instret", o_instret, 64'd0);

        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The block SHALL have parameter D_WIDTH, default 32, datapath width.
REQ-002 The block SHALL have parameter A_WIDTH, default 5, register-address width.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock for the MEM/WB register.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port i_stall  input  1  hold the MEM/WB register.
REQ-006 The block SHALL have port i_flush  input  1  load a bubble into the MEM/WB register.
REQ-007 The block SHALL have port i_valid  input  1  MEM-stage instruction valid.
REQ-008 The block SHALL have port i_rd  input  A_WIDTH  destination register.
REQ-009 The block SHALL have port i_wen  input  1  instruction writes rd.
REQ-010 The block SHALL have port i_wb_sel  input  2  writeback source: 00 ALU, 01 load, 10 PC+4, 11 reserved.
REQ-011 The block SHALL have ports i_alu_result, i_pc_plus4  input  D_WIDTH  MEM-stage results.
REQ-012 The block SHALL have ports i_funct3 (input, 3) and i_addr_lo (input, 2): load type and byte offset.
REQ-013 The block SHALL have port i_dmem_rdata  input  D_WIDTH  synchronous data-memory word, valid in the WB cycle.
REQ-014 The block SHALL have ports o_wen_rf (1), o_waddr (A_WIDTH), o_wdata (D_WIDTH)  output  register-file write port.
REQ-015 The block SHALL have port o_illegal_load  output  1  WB load carries unsupported funct3.
REQ-016 The block SHALL have port o_instret  output  64  retired-instruction count (WB_INSTRET_EN only).

Function
REQ-017 On rising clk: i_flush=1 SHALL clear valid_q, overriding i_stall; else i_stall=1 SHALL hold all state; else all MEM inputs except i_dmem_rdata SHALL be captured.
REQ-018 o_wen_rf SHALL equal valid_q & wen_q & (rd_q != 0), combinationally; o_waddr SHALL equal rd_q.
REQ-019 o_wdata SHALL be alu_q (sel 00), aligned load (sel 01), pc4_q (sel 10), 0 with o_wen_rf forced 0 (sel 11).
REQ-020 Load alignment SHALL be combinational on i_dmem_rdata: LB/LBU select byte addr_lo_q, LH/LHU select half addr_lo_q[1] (addr_lo_q[0] ignored), LW whole word; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-021 funct3 011/110/111 with sel 01 and valid_q SHALL give o_wdata=0, o_wen_rf=0, o_illegal_load=1; otherwise o_illegal_load=0.
REQ-022 All outputs SHALL settle within the high phase so the falling-edge register file captures them; write-through to same-cycle ID reads relies on this.
REQ-023 Latency SHALL be one cycle MEM->WB; a stalled WB instruction SHALL keep asserting its write each cycle (idempotent).
REQ-024 Simultaneous flush and stall SHALL yield a bubble; flush SHALL NOT cancel the instruction already in WB.

Reset
REQ-025 rst_n low SHALL asynchronously clear valid_q, wen_q, rd_q, sel_q, alu_q, pc4_q, funct3_q, addr_lo_q and instret to 0.
REQ-026 During reset o_wen_rf, o_waddr, o_wdata, o_illegal_load SHALL read 0; reset mid-stall SHALL discard the held instruction.

Configuration
REQ-027 With macro WB_INSTRET_EN defined, a 64-bit counter SHALL increment when valid_q & ~i_stall, wrapping 2^64-1 -> 0.
REQ-028 Without WB_INSTRET_EN, o_instret SHALL be tied to 0 and no counter flops SHALL exist.

Structure
REQ-029 wb_sel encodings, funct3 load codes and D_WIDTH/A_WIDTH defaults SHALL live in shared package rv32i_pkg.
REQ-030 Load alignment SHALL be sub-module load_align (combinational: rdata, funct3, addr_lo -> data, illegal).

Verification
REQ-031 LB, addr_lo=3, rdata=0x80FF_0000 -> o_wdata=0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-032 LH, addr_lo=2, rdata=0x8001_1234 -> 0xFFFF_8001; LHU -> 0x0000_8001.
REQ-033 ALU write rd=0, result 0x1234 -> o_wen_rf=0; rd=5 -> o_wen_rf=1, o_waddr=5, o_wdata=0x1234.
REQ-034 i_stall=1 three cycles with WB jal (sel 10, pc4=0x100) -> o_wdata=0x100 held, instret +1 only on release.
REQ-035 i_flush=1 and i_stall=1 same edge -> next cycle o_wen_rf=0; funct3=011 load -> o_illegal_load=1, o_wen_rf=0.
REQ-036 rst_n pulsed low mid-operation -> all outputs 0 immediately, o_instret=0.
